// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: op codes, instruction field layout,
// FSM state encoding and the instruction decode helper.
package alu_sequencer_pkg;

  localparam int INSTR_W     = 16;
  localparam int OP_HI       = 15;
  localparam int OP_LO       = 13;
  localparam int USE_IMM_BIT = 12;
  localparam int RD_HI       = 11;
  localparam int RD_LO       = 9;
  localparam int RS1_HI      = 8;
  localparam int RS1_LO      = 6;
  localparam int RS2_HI      = 5;
  localparam int RS2_LO      = 3;
  localparam int IMM_HI      = 5;
  localparam int IMM_LO      = 0;
  localparam int REG_IDX_W   = RD_HI - RD_LO + 1;
  localparam int IMM_W       = IMM_HI - IMM_LO + 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_OR  = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_CMP = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_LATCH_Y = 3'd4,
    ST_WB      = 3'd5
  } seq_state_e;

  typedef struct packed {
    alu_op_e                op;
    logic                   use_imm;
    logic [REG_IDX_W-1:0]   rd;
    logic [REG_IDX_W-1:0]   rs1;
    logic [REG_IDX_W-1:0]   rs2;
    logic [IMM_W-1:0]       imm6;
  } instr_t;

  // rs2 and imm6 overlap in the encoding; use_imm picks which one matters.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op      = alu_op_e'(raw[OP_HI:OP_LO]);
    d.use_imm = raw[USE_IMM_BIT];
    d.rd      = raw[RD_HI:RD_LO];
    d.rs1     = raw[RS1_HI:RS1_LO];
    d.rs2     = raw[RS2_HI:RS2_LO];
    d.imm6    = raw[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU operand/strobe bus and debug read port of the sequencer.
// slave = the sequencer itself; master = the CPU front end plus the ALU it drives.
interface alu_sequencer_if
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [2:0]         alu_sel;
  logic               alu_init_a;
  logic               alu_init_b;
  logic               alu_init_y;
  logic [DATA_W-1:0]  alu_y;
  logic               done;
  logic [DATA_W-1:0]  result;
  logic [ADDR_W-1:0]  dbg_addr;
  logic [DATA_W-1:0]  dbg_data;

  modport slave (
    input  instr_valid, instr, alu_y, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_sel,
           alu_init_a, alu_init_b, alu_init_y,
           done, result, dbg_data
  );

  modport master (
    output instr_valid, instr, alu_y, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_sel,
           alu_init_a, alu_init_b, alu_init_y,
           done, result, dbg_data
  );

endinterface

// File: rtl/alu_sequencer_regfile.sv
// Architectural register file: two combinational operand reads, one debug read,
// one synchronous write port; r0 is hardwired to zero.
module seq_regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [REG_CNT];

  // NOTE: this storage is reset explicitly because a reset must leave every
  // register reading 0; that forces flops rather than a RAM macro here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      // NOTE: non-blocking so every flop samples pre-edge values, whatever the
      // order of statements in this block.
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : mem_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer in front of a strobe-latched ALU: accepts one instruction, drives
// A/B/Y load strobes in order, then writes the ALU result back to the register file.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  seq_state_e           state_q;
  logic                 ready_q;
  logic [ADDR_W-1:0]    rd_q;
  logic [ADDR_W-1:0]    rs2_q;
  logic                 use_imm_q;
  logic [IMM_W-1:0]     imm6_q;
  logic [DATA_W-1:0]    alu_a_q;
  logic [DATA_W-1:0]    alu_b_q;
  alu_op_e              alu_sel_q;
  logic                 init_a_q;
  logic                 init_b_q;
  logic                 init_y_q;
  logic                 done_q;
  logic [DATA_W-1:0]    result_q;

  instr_t               instr_dec;
  logic [DATA_W-1:0]    rf_a;
  logic [DATA_W-1:0]    rf_b;
  logic [DATA_W-1:0]    op_b_d;
  logic                 rf_we;

  assign instr_dec = decode_instr(bus.instr);
  assign rf_we     = (state_q == ST_WB);

  seq_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (bus.alu_y),
    .raddr_a_i  (ADDR_W'(instr_dec.rs1)),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (rs2_q),
    .rdata_b_o  (rf_b),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data)
  );

  // NOTE: assign a default before any conditional so no path leaves op_b_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op_b_d = rf_b;
    if (use_imm_q) begin
      op_b_d = DATA_W'(imm6_q);
    end
  end

  // Operand A is read at the accept edge straight from the incoming instruction;
  // operand B one edge later from the captured rs2, so both reads see the
  // writeback of the previous instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      rd_q      <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
      imm6_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= OP_ADD;
      init_a_q  <= 1'b0;
      init_b_q  <= 1'b0;
      init_y_q  <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      init_a_q <= 1'b0;
      init_b_q <= 1'b0;
      init_y_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.instr_valid && ready_q) begin
            rd_q      <= ADDR_W'(instr_dec.rd);
            rs2_q     <= ADDR_W'(instr_dec.rs2);
            use_imm_q <= instr_dec.use_imm;
            imm6_q    <= instr_dec.imm6;
            alu_a_q   <= rf_a;
            alu_sel_q <= instr_dec.op;
            init_a_q  <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          alu_b_q  <= op_b_d;
          init_b_q <= 1'b1;
          state_q  <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          init_y_q <= 1'b1;
          state_q  <= ST_LATCH_Y;
        end
        ST_LATCH_Y: begin
          state_q <= ST_WB;
        end
        ST_WB: begin
          result_q <= bus.alu_y;
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.alu_init_a  = init_a_q;
  assign bus.alu_init_b  = init_b_q;
  assign bus.alu_init_y  = init_y_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural strobe-latched ALU, a
// register-array reference model, directed cases and random instructions.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   done_cyc = 0;

  logic [31:0] rf_m [8];
  logic [31:0] alu_a_lat = '0;
  logic [31:0] alu_b_lat = '0;
  logic [31:0] alu_y_lat = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_sequencer_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  alu_sequencer #(.DATA_W(32), .REG_CNT(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << b[4:0];
      default: return (a < b) ? 32'd1 : ((a == b) ? 32'd2 : 32'd3);
    endcase
  endfunction

  // Stand-in ALU: each strobe latches on the edge that ends its high cycle.
  always @(posedge clk) begin
    if (bus.alu_init_a) alu_a_lat <= bus.alu_a;
    if (bus.alu_init_b) alu_b_lat <= bus.alu_b;
    if (bus.alu_init_y) alu_y_lat <= alu_ref(bus.alu_sel, alu_a_lat, alu_b_lat);
  end
  assign bus.alu_y = alu_y_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int ui, input int rd,
                                     input int rs1, input int low6);
    return {op[2:0], ui[0], rd[2:0], rs1[2:0], low6[5:0]};
  endfunction

  function automatic logic [31:0] strobes();
    return {28'd0, bus.alu_init_a, bus.alu_init_b, bus.alu_init_y, bus.done};
  endfunction

  // Expected {init_a, init_b, init_y, done} for the Nth cycle after accept.
  function automatic logic [31:0] exp_strobes(input int c);
    case (c)
      1:       return 32'h8;
      2:       return 32'h4;
      4:       return 32'h2;
      6:       return 32'h1;
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_instr(input logic [15:0] ins, input bit hold, input logic [15:0] nxt);
    logic [2:0]  op, rd, rs1, rs2;
    logic        ui;
    logic [31:0] a_exp, b_exp, y_exp;
    int          waitc;
    op  = ins[15:13];
    ui  = ins[12];
    rd  = ins[11:9];
    rs1 = ins[8:6];
    rs2 = ins[5:3];
    a_exp = rf_m[rs1];
    b_exp = ui ? {26'd0, ins[5:0]} : rf_m[rs2];
    y_exp = alu_ref(op, a_exp, b_exp);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    waitc = 0;
    while (bus.instr_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.instr_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("strobes_c%0d", c), strobes(), exp_strobes(c));
      check($sformatf("ready_c%0d", c), {31'd0, bus.instr_ready}, (c == 6) ? 32'd1 : 32'd0);
      if (c == 1) begin
        bus.instr_valid = 1'b0;
        check("alu_a", bus.alu_a, a_exp);
        check("alu_sel", {29'd0, bus.alu_sel}, {29'd0, op});
      end
      if (c == 2) begin
        check("alu_b", bus.alu_b, b_exp);
        if (hold) begin
          bus.instr       = nxt;
          bus.instr_valid = 1'b1;
        end
      end
      if (c == 5) bus.dbg_addr = rd;
      if (c == 6) begin
        done_cyc = cyc;
        if (rd != 3'd0) rf_m[rd] = y_exp;
        check("result", bus.result, y_exp);
        check("wb_dbg", bus.dbg_data, rf_m[rd]);
        check("alu_a_stable", bus.alu_a, a_exp);
        check("alu_b_stable", bus.alu_b, b_exp);
      end
    end
  endtask

  task automatic dbg_check(input string tag, input int r, input logic [31:0] exp);
    bus.dbg_addr = r[2:0];
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  initial begin
    int t1;
    int extra;
    logic [15:0] ins;
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.dbg_addr    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_strobes", strobes(), 32'h0);
    check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_sel", {29'd0, bus.alu_sel}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    for (int r = 0; r < 8; r++) begin
      bus.dbg_addr = r[2:0];
      @(negedge clk);
      check($sformatf("rst_r%0d", r), bus.dbg_data, 32'd0);
    end

    // Back-to-back dependent adds
    run_instr(mk(0, 1, 1, 0, 5), 1'b0, '0);
    t1 = done_cyc;
    run_instr(mk(0, 1, 2, 1, 7), 1'b0, '0);
    check("done_interval", done_cyc - t1, 32'd6);
    dbg_check("r2_is_12", 2, 32'd12);

    // Wraparound subtract and compare ops
    run_instr(mk(1, 0, 3, 0, 1 << 3), 1'b0, '0);
    dbg_check("r3_wrap", 3, 32'hFFFF_FFFB);
    run_instr(mk(7, 0, 4, 1, 2 << 3), 1'b0, '0);
    dbg_check("cmp_lt", 4, 32'd1);
    run_instr(mk(7, 0, 5, 1, 1 << 3), 1'b0, '0);
    dbg_check("cmp_eq", 5, 32'd2);

    // Write to r0 is discarded but still completes
    run_instr(mk(0, 1, 0, 1, 1), 1'b0, '0);
    check("r0_result", bus.result, 32'd6);
    dbg_check("r0_still_0", 0, 32'd0);

    // instr_valid raised during LOAD_B is held pending, then accepted once
    run_instr(mk(0, 1, 6, 4, 3), 1'b1, mk(0, 1, 7, 6, 1));
    run_instr(mk(0, 1, 7, 6, 1), 1'b0, '0);
    dbg_check("held_r7", 7, 32'd5);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1) extra++;
    end
    check("held_once", extra, 32'd0);

    // Reset during LATCH_Y aborts without writeback
    ins = mk(0, 1, 6, 1, 9);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("abort_c1_init_a", strobes(), 32'h8);
    repeat (3) @(negedge clk);
    check("abort_pre_init_y", strobes(), 32'h2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    check("abort_strobes", strobes(), 32'h0);
    check("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) extra++;
    end
    check("abort_no_done", extra, 32'd0);
    dbg_check("abort_r6", 6, 32'd0);

    // Random instructions against the reference model
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_instr(mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 63)), 1'b0, '0);
    end
    for (int r = 0; r < 8; r++) begin
      bus.dbg_addr = r[2:0];
      @(negedge clk);
      check($sformatf("final_r%0d", r), bus.dbg_data, rf_m[r]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
